video_sram_controller: RTL



---
 rtl/video_sram_controller.sv | 105 ++++++++++
 1 files changed

// File: rtl/video_sram_controller.sv
// Avalon-MM slave to 16-bit asynchronous SRAM bridge: one Avalon command becomes one timed
// SRAM access. All SRAM pins come straight from registers; only waitrequest is combinational.
module video_sram_controller #(
  parameter int unsigned SRAM_AW      = 18,
  parameter int unsigned SRAM_DW      = 16,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [SRAM_AW-1:0]   avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [SRAM_DW-1:0]   avs_writedata,
  input  logic [SRAM_DW/8-1:0] avs_byteenable,
  output logic [SRAM_DW-1:0]   avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 avs_waitrequest,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic [SRAM_DW/8-1:0] sram_be_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_dq
);

  localparam int unsigned MaxCycles = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles) > 4) ? $clog2(MaxCycles) : 4;
  localparam logic [CntW-1:0] ReadLast  = CntW'(READ_CYCLES - 1);
  localparam logic [CntW-1:0] WriteLast = CntW'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StRecover} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [SRAM_DW-1:0]  wdata_q;
  logic                dq_oe_q;

  assign avs_waitrequest = sys_rst | (state_q != StIdle);

  // dq_oe_q toggles on exactly the same edges as sram_we_n, so dq is only driven while we_n=0.
  assign sram_dq = dq_oe_q ? wdata_q : {SRAM_DW{1'bz}};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      wdata_q           <= '0;
      dq_oe_q           <= 1'b0;
      sram_ce_n         <= 1'b1;
      sram_oe_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      sram_be_n         <= '1;
      sram_addr         <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (avs_read || avs_write) begin
            sram_addr <= avs_address;
            sram_be_n <= ~avs_byteenable;
            wdata_q   <= avs_writedata;
            cnt_q     <= '0;
            sram_ce_n <= 1'b0;
            // Write wins when both strobes are high; the read is silently dropped.
            if (avs_write) begin
              sram_we_n <= 1'b0;
              dq_oe_q   <= 1'b1;
              state_q   <= StWrite;
            end else begin
              sram_oe_n <= 1'b0;
              state_q   <= StRead;
            end
          end
        end
        StRead: begin
          if (cnt_q == ReadLast) begin
            avs_readdata      <= sram_dq;
            avs_readdatavalid <= 1'b1;
            sram_ce_n         <= 1'b1;
            sram_oe_n         <= 1'b1;
            state_q           <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrite: begin
          if (cnt_q == WriteLast) begin
            sram_we_n <= 1'b1;
            sram_ce_n <= 1'b1;
            dq_oe_q   <= 1'b0;
            state_q   <= StRecover;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRecover: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule
